// File: rtl/cell4_stim_pkg.sv
// Shared types and helpers for the 4-input cell stimulus driver.
package cell4_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_FINISH
    } state_e;

    typedef enum logic [1:0] {
        MODE_GRAY = 2'b00,
        MODE_ARC  = 2'b01,
        MODE_ALL  = 2'b10
    } mode_e;

    // Drive applied whenever no run is active; an ideal NAND4 answers QN=0.
    localparam logic [3:0] VEC_QUIESCENT = 4'b1111;

    // Ideal NAND4 response to a drive vector.
    function automatic logic nand4_exp(input logic [3:0] vec);
        return ~&vec;
    endfunction

    // The unused MODE code 11 behaves as all-toggle.
    function automatic mode_e mode_decode(input logic [1:0] mode);
        return (mode == 2'b11) ? MODE_ALL : mode_e'(mode);
    endfunction

endpackage

// File: rtl/cell4_stim_seq.sv
// Vector sequencer: produces the current drive vector for the latched run
// type and flags the final vector of the final repetition.
module cell4_stim_seq
    import cell4_stim_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [1:0]       mode,
    input  logic [1:0]       arc_sel,
    input  logic [CNT_W-1:0] reps,
    output logic [3:0]       vec,
    output logic             last
);

    mode_e            mode_q;
    logic [1:0]       arc_q;
    logic [3:0]       idx;
    logic [CNT_W-1:0] reps_left;
    logic             pass_end;

    // Gray passes are 16 vectors long; arc and all-toggle passes are two.
    assign pass_end = (mode_q == MODE_GRAY) ? (idx == 4'd15) : idx[0];
    assign last     = pass_end && (reps_left == CNT_W'(1));

    // Latch run configuration on start, then walk index and repetitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_GRAY;
            arc_q     <= 2'd0;
            idx       <= 4'd0;
            reps_left <= '0;
        end else if (start) begin
            mode_q    <= mode_decode(mode);
            arc_q     <= arc_sel;
            idx       <= 4'd0;
            reps_left <= (reps == '0) ? CNT_W'(1) : reps;
        end else if (step) begin
            if (pass_end) begin
                idx       <= 4'd0;
                reps_left <= reps_left - 1'b1;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Map the pass index onto the drive vector for the latched run type.
    always_comb begin
        vec = VEC_QUIESCENT;
        case (mode_q)
            MODE_GRAY: vec = idx ^ (idx >> 1);
            MODE_ARC: begin
                vec          = VEC_QUIESCENT;
                vec[arc_q]   = idx[0];
            end
            default:   vec = {4{idx[0]}};
        endcase
    end

endmodule

// File: rtl/cell4_stim_driver.sv
// Stimulus driver and response checker for NAND4-class library cells.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | quiescent 1111 drive, waiting for START
// ST_DRIVE  | current vector applied, settle timer loaded
// ST_SETTLE | waiting SETTLE cycles for the cell output to settle
// ST_CHECK  | QN compared against the ideal NAND4 response
// ST_FINISH | DONE pulse, drive back to 1111
module cell4_stim_driver
    import cell4_stim_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       MODE,
    input  logic [1:0]       ARC_SEL,
    input  logic [CNT_W-1:0] REPS,
    output logic             IN1,
    output logic             IN2,
    output logic             IN3,
    output logic             IN4,
    input  logic             QN,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [3:0]       LAST_FAIL_VEC
);

    state_e           state, state_nxt;
    logic [7:0]       settle_cnt;
    logic             seq_start, seq_step, seq_last;
    logic [3:0]       seq_vec, drive_vec;
    logic             busy, done, mismatch;
    logic [CNT_W-1:0] err_cnt;
    logic [3:0]       last_fail;

    cell4_stim_seq #(.CNT_W(CNT_W)) u_seq (
        .clk     (CLK),
        .rst     (RST),
        .start   (seq_start),
        .step    (seq_step),
        .mode    (MODE),
        .arc_sel (ARC_SEL),
        .reps    (REPS),
        .vec     (seq_vec),
        .last    (seq_last)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_nxt = state;
        seq_start = 1'b0;
        seq_step  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        drive_vec = seq_vec;
        case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                drive_vec = VEC_QUIESCENT;
                if (START) begin
                    seq_start = 1'b1;
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE:  state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == 8'd0) state_nxt = ST_CHECK;
            ST_CHECK: begin
                seq_step  = 1'b1;
                state_nxt = seq_last ? ST_FINISH : ST_DRIVE;
            end
            ST_FINISH: begin
                done      = 1'b1;
                drive_vec = VEC_QUIESCENT;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy      = 1'b0;
                drive_vec = VEC_QUIESCENT;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Settle down-counter: loaded in DRIVE, terminal count ends SETTLE.
    always_ff @(posedge CLK) begin
        if (RST)
            settle_cnt <= 8'd0;
        else if (state == ST_DRIVE)
            settle_cnt <= 8'(SETTLE - 1);
        else if (state == ST_SETTLE && settle_cnt != 8'd0)
            settle_cnt <= settle_cnt - 1'b1;
    end

    assign mismatch = (state == ST_CHECK) && (QN != nand4_exp(seq_vec));

    // Mismatch bookkeeping; the count saturates rather than wrapping.
    always_ff @(posedge CLK) begin
        if (RST) begin
            err_cnt   <= '0;
            last_fail <= 4'd0;
        end else if (seq_start) begin
            err_cnt   <= '0;
        end else if (mismatch) begin
            if (err_cnt != {CNT_W{1'b1}})
                err_cnt <= err_cnt + 1'b1;
            last_fail <= seq_vec;
        end
    end

    assign {IN4, IN3, IN2, IN1} = drive_vec;
    assign BUSY          = busy;
    assign DONE          = done;
    assign ERR_CNT       = err_cnt;
    assign LAST_FAIL_VEC = last_fail;

endmodule

// File: tb/tb_cell4_stim_driver.sv
// Self-checking bench: two driver instances (SETTLE=2/CNT_W=8 and
// SETTLE=1/CNT_W=3) against a vector-list reference model.
module tb_cell4_stim_driver;

    localparam int S_A = 2;
    localparam int W_A = 8;
    localparam int S_B = 1;
    localparam int W_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] mode, arc;
    logic [7:0] reps;
    logic       start_a, start_b;
    logic [1:0] fault_a, fault_b;
    logic [3:0] fvec_a, fvec_b;

    logic       in1_a, in2_a, in3_a, in4_a, qn_a, busy_a, done_a;
    logic [7:0] err_a;
    logic [3:0] lfv_a;
    logic       in1_b, in2_b, in3_b, in4_b, qn_b, busy_b, done_b;
    logic [2:0] err_b;
    logic [3:0] lfv_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] lfv_model[2];

    // Cell model: 0 ideal, 1 stuck-0, 2 stuck-1, 3 ideal but wrong on fv.
    function automatic logic resp(input logic [1:0] f, input logic [3:0] fv,
                                  input logic [3:0] v);
        logic ideal;
        ideal = (v != 4'hF);
        case (f)
            2'd0:    return ideal;
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return ideal ^ (v == fv);
        endcase
    endfunction

    assign qn_a = resp(fault_a, fvec_a, {in4_a, in3_a, in2_a, in1_a});
    assign qn_b = resp(fault_b, fvec_b, {in4_b, in3_b, in2_b, in1_b});

    cell4_stim_driver #(.SETTLE(S_A), .CNT_W(W_A)) dut_a (
        .CLK(clk), .RST(rst), .START(start_a), .MODE(mode), .ARC_SEL(arc),
        .REPS(reps), .IN1(in1_a), .IN2(in2_a), .IN3(in3_a), .IN4(in4_a),
        .QN(qn_a), .BUSY(busy_a), .DONE(done_a), .ERR_CNT(err_a),
        .LAST_FAIL_VEC(lfv_a)
    );

    cell4_stim_driver #(.SETTLE(S_B), .CNT_W(W_B)) dut_b (
        .CLK(clk), .RST(rst), .START(start_b), .MODE(mode), .ARC_SEL(arc),
        .REPS(reps[2:0]), .IN1(in1_b), .IN2(in2_b), .IN3(in3_b), .IN4(in4_b),
        .QN(qn_b), .BUSY(busy_b), .DONE(done_b), .ERR_CNT(err_b),
        .LAST_FAIL_VEC(lfv_b)
    );

    logic       sel;
    logic [3:0] in_s, lfv_s;
    logic       busy_s, done_s;
    logic [7:0] err_s;

    // Observe whichever instance is under test.
    always_comb begin
        if (sel) begin
            in_s = {in4_b, in3_b, in2_b, in1_b}; busy_s = busy_b; done_s = done_b;
            err_s = {5'd0, err_b}; lfv_s = lfv_b;
        end else begin
            in_s = {in4_a, in3_a, in2_a, in1_a}; busy_s = busy_a; done_s = done_a;
            err_s = err_a; lfv_s = lfv_a;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected vector list built straight from the sequence rules.
    task automatic gen_seq(input int md, input logic [1:0] as, input int rp);
        int n;
        logic [3:0] lo;
        exp_q.delete();
        n = (rp == 0) ? 1 : rp;
        for (int r = 0; r < n; r++) begin
            if (md == 0) begin
                for (int i = 0; i < 16; i++) exp_q.push_back(4'(i ^ (i >> 1)));
            end else if (md == 1) begin
                lo = 4'hF;
                lo[as] = 1'b0;
                exp_q.push_back(lo);
                exp_q.push_back(4'hF);
            end else begin
                exp_q.push_back(4'h0);
                exp_q.push_back(4'hF);
            end
        end
    endtask

    task automatic run(input bit s, input int md, input logic [1:0] as, input int rp,
                       input logic [1:0] fault, input logic [3:0] fv,
                       input bit disturb, input string tag);
        int st, w, per, n, lim, mism, maxv, exp_err;
        int bad_in, bad_busy, done_cnt, done_at;
        logic [3:0] lf;
        st = s ? S_B : S_A;
        w  = s ? W_B : W_A;
        per = st + 2;
        sel = s;
        if (s) begin fault_b = fault; fvec_b = fv; end
        else   begin fault_a = fault; fvec_a = fv; end
        gen_seq(md, as, rp);
        n = exp_q.size();
        lim = n * per + 1;
        mism = 0;
        lf = lfv_model[s];
        foreach (exp_q[k]) begin
            if (resp(fault, fv, exp_q[k]) != (exp_q[k] != 4'hF)) begin
                mism++;
                lf = exp_q[k];
            end
        end
        maxv = (1 << w) - 1;
        exp_err = (mism > maxv) ? maxv : mism;
        bad_in = 0; bad_busy = 0; done_cnt = 0; done_at = -1;

        @(negedge clk);
        mode = 2'(md); arc = as; reps = 8'(rp);
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= lim + 3; c++) begin
            @(negedge clk);
            start_a = 1'b0; start_b = 1'b0;
            if (c <= n * per) begin
                if (in_s !== exp_q[(c - 1) / per]) bad_in++;
            end else if (in_s !== 4'hF) bad_in++;
            if (busy_s !== ((c <= lim) ? 1'b1 : 1'b0)) bad_busy++;
            if (done_s === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (disturb) begin
                if (c == per + 1) begin
                    if (s) start_b = 1'b1; else start_a = 1'b1;
                    mode = ~2'(md);
                    arc = as + 2'd1;
                end
                if (c == 3 * per) mode = 2'($urandom_range(0, 3));
                if (c == lim) begin
                    if (s) start_b = 1'b1; else start_a = 1'b1;
                end
            end
        end
        check({tag, "_in_seq"}, bad_in, 0);
        check({tag, "_busy"}, bad_busy, 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_at"}, done_at, lim);
        check({tag, "_err_cnt"}, err_s, exp_err);
        check({tag, "_last_fail"}, lfv_s, lf);
        lfv_model[s] = lf;
    endtask

    initial begin
        int bad, md, rp;
        logic [1:0] as, ft;
        logic [3:0] fv;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        mode = 2'd0; arc = 2'd0; reps = 8'd1;
        fault_a = 2'd0; fault_b = 2'd0; fvec_a = 4'd0; fvec_b = 4'd0;
        sel = 1'b0;
        lfv_model[0] = 4'd0; lfv_model[1] = 4'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        sel = 1'b0; #1;
        check("rst_in_a", in_s, 4'hF);
        check("rst_busy_a", busy_s, 0);
        check("rst_done_a", done_s, 0);
        check("rst_err_a", err_s, 0);
        check("rst_lfv_a", lfv_s, 0);
        sel = 1'b1; #1;
        check("rst_in_b", in_s, 4'hF);
        check("rst_busy_b", busy_s, 0);
        rst = 1'b0;

        run(0, 0, 2'd0, 1, 2'd0, 4'd0, 0, "gray_ideal");
        run(0, 0, 2'd0, 1, 2'd1, 4'd0, 0, "gray_stuck0");
        check("gray_stuck0_lfv_1000", lfv_a, 4'b1000);
        run(0, 1, 2'd2, 3, 2'd0, 4'd0, 0, "arc2_ideal");
        run(1, 0, 2'd0, 2, 2'd1, 4'd0, 0, "sat_w3");
        check("sat_w3_err7", err_b, 3'd7);
        run(0, 2, 2'd0, 2, 2'd3, 4'h0, 1, "disturb");
        run(1, 3, 2'd1, 0, 2'd2, 4'd0, 0, "mode3_reps0");

        for (int t = 0; t < 6; t++) begin
            md = int'($urandom_range(0, 3));
            as = 2'($urandom_range(0, 3));
            rp = int'($urandom_range(0, 3));
            ft = 2'($urandom_range(0, 3));
            fv = 4'($urandom_range(0, 15));
            run(1'($urandom_range(0, 1)), md, as, rp, ft, fv, 1'($urandom_range(0, 1)),
                $sformatf("rnd%0d", t));
        end

        // Reset while vector 5 is settling.
        sel = 1'b0; fault_a = 2'd1;
        @(negedge clk);
        mode = 2'd0; reps = 8'd1; start_a = 1'b1;
        @(posedge clk);
        bad = 0;
        for (int c = 1; c <= 5 * (S_A + 2) + 2; c++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (done_a) bad++;
        end
        check("rmid_err_before", err_a, 5);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rmid_busy", busy_a, 0);
        check("rmid_in", {in4_a, in3_a, in2_a, in1_a}, 4'hF);
        check("rmid_err", err_a, 0);
        check("rmid_lfv", lfv_a, 0);
        rst = 1'b0;
        lfv_model[0] = 4'd0; lfv_model[1] = 4'd0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done_a || busy_a) bad++;
        end
        check("rmid_no_done", bad, 0);
        run(0, 0, 2'd0, 1, 2'd0, 4'd0, 0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
